accumulator_sequencer: RTL and testbench



---
 rtl/accumulator_sequencer_if.sv | 14 +
 rtl/accumulator_sequencer.sv | 118 +++++++++++
 tb/tb_accumulator_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_sequencer_if.sv
// Tile command channel from the instruction decoder to the accumulator sequencer.
// A command transfers on a clock edge where cmd_valid && cmd_ready; the requester holds it stable until then.
interface accumulator_sequencer_if #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] cmd_addr;

    modport master (output cmd_valid, cmd_len, cmd_addr, input cmd_ready);
    modport slave  (input cmd_valid, cmd_len, cmd_addr, output cmd_ready);
endinterface

// File: rtl/accumulator_sequencer.sv
// Sequences one Accumulator tile: clear, gate N beats, drain the adder pipeline, store.
// Optional macro ACC_SEQ_ADDR_AUTOINC_EN: store address comes from an internal wrapping pointer.
module accumulator_sequencer #(
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 2,
    parameter int ADDR_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    accumulator_sequencer_if.slave  cmd,
    input  logic                    data_valid,
    output logic                    acc_in_en,
    output logic                    acc_reset,
    output logic                    store_output,
    output logic [ADDR_W-1:0]       op_buffer_address,
    output logic                    busy,
    output logic                    done,
    output logic                    stray_beat,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_STORE = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [3:0]        drain_cnt, drain_cnt_nxt;
    logic [CNT_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] op_addr_q;
    logic              stray_q;
    logic [ADDR_W-1:0] addr_src;

`ifdef ACC_SEQ_ADDR_AUTOINC_EN
    logic [ADDR_W-1:0] addr_ptr;
    logic              unused_cmd_addr;

    assign unused_cmd_addr = ^cmd.cmd_addr;
    assign addr_src        = addr_ptr;

    // Pointer advances once per completed store and wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst)                  addr_ptr <= '0;
        else if (state == S_STORE) addr_ptr <= addr_ptr + 1'b1;
    end
`else
    assign addr_src = cmd.cmd_addr;
`endif

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        drain_cnt_nxt = drain_cnt;
        case (state)
            S_IDLE:  if (cmd.cmd_valid) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (len_q != '0) ? S_ACCUM : S_DRAIN;
            S_ACCUM: begin
                if (data_valid) begin
                    if (beat_cnt == len_q - 1'b1) begin
                        state_nxt    = S_DRAIN;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 4'(DRAIN_CYCLES - 1)) begin
                    state_nxt     = S_STORE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 1'b1;
                end
            end
            S_STORE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            op_addr_q <= '0;
            stray_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (state == S_IDLE && cmd.cmd_valid) begin
                len_q  <= cmd.cmd_len;
                addr_q <= addr_src;
            end
            // Loaded on entry to STORE so the address is live during the pulse and held after.
            if (state_nxt == S_STORE) op_addr_q <= addr_q;
            if (data_valid && state != S_ACCUM) stray_q <= 1'b1;
        end
    end

    assign cmd.cmd_ready      = (state == S_IDLE);
    assign busy               = (state != S_IDLE);
    assign acc_reset          = (state == S_CLEAR);
    assign store_output       = (state == S_STORE);
    assign done               = (state == S_STORE);
    assign acc_in_en          = (state == S_ACCUM) && data_valid;
    assign op_buffer_address  = op_addr_q;
    assign stray_beat         = stray_q;
    assign state_dbg          = state;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer: directed scenarios plus randomized tiles vs a timing model.
module tb_accumulator_sequencer;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 4;
    localparam int D      = 2;
    localparam int VW     = 7 + ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accumulator_sequencer_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) cmd_if ();

    logic              data_valid;
    logic              acc_in_en, acc_reset, store_output, busy, done, stray_beat;
    logic [ADDR_W-1:0] op_buffer_address;
    logic [2:0]        dbg_state_unused;

    accumulator_sequencer #(.CNT_W(CNT_W), .DRAIN_CYCLES(D), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd               (cmd_if.slave),
        .data_valid        (data_valid),
        .acc_in_en         (acc_in_en),
        .acc_reset         (acc_reset),
        .store_output      (store_output),
        .op_buffer_address (op_buffer_address),
        .busy              (busy),
        .done              (done),
        .stray_beat        (stray_beat),
        .state_dbg         (dbg_state_unused)
    );

    int                n_cmp = 0;
    int                n_err = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] last_stored;
    logic [ADDR_W-1:0] exp_ptr;
    logic              exp_stray;
    bit                pat[$];

    function automatic logic [VW-1:0] observed();
        return {cmd_if.cmd_ready, busy, acc_reset, acc_in_en, store_output, done, stray_beat, op_buffer_address};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_stray   = 1'b0;
        last_stored = '0;
        exp_ptr     = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp_v;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_len = '0; cmd_if.cmd_addr = '0; data_valid = 1'b0;
        repeat (2) step();
        #1;
        exp_v = {1'b1, 6'b0, {ADDR_W{1'b0}}};
        n_cmp++;
        if (observed() !== exp_v) begin
            n_err++;
            $display("FAIL reset_state got=%b exp=%b", observed(), exp_v);
        end
        rst = 1'b0;
        model_reset();
        step();
    endtask

    // One tile from IDLE: command in cycle 0, beats only counted from cycle 2 while fewer than len seen.
    task automatic run_tile(input int len, input logic [ADDR_W-1:0] addr, input int pct, input bit stray_ok);
        int            beats   = 0;
        int            store_c = -1;
        bit            fin     = 0;
        bit            in_win;
        logic          dv;
        logic [ADDR_W-1:0] a_exp, got_a;
        logic [VW-1:0] exp_v;
        bit            e_ready, e_busy, e_store;
        logic [ADDR_W-1:0] e_addr;
`ifdef ACC_SEQ_ADDR_AUTOINC_EN
        a_exp = exp_ptr;
`else
        a_exp = addr;
`endif
        exp_q.push_back(a_exp);
        if (len == 0) store_c = 2 + D;
        for (int c = 0; c < 3000; c++) begin
            in_win = (c >= 2) && (beats < len);
            if (in_win) begin
                if (pct < 0) dv = (pat.size() > c - 2) ? pat[c-2] : 1'b1;
                else         dv = ($urandom_range(99) < pct);
            end else begin
                dv = stray_ok ? ($urandom_range(99) < 20) : 1'b0;
            end
            cmd_if.cmd_valid = (c == 0);
            cmd_if.cmd_len   = CNT_W'(len);
            cmd_if.cmd_addr  = addr;
            data_valid       = dv;
            #1;
            if (in_win && dv) begin
                beats++;
                if (beats == len) store_c = c + 1 + D;
            end
            e_ready = (c == 0) || (store_c >= 0 && c == store_c + 1);
            e_busy  = (c >= 1) && !(store_c >= 0 && c > store_c);
            e_store = (store_c >= 0 && c == store_c);
            e_addr  = (store_c >= 0 && c >= store_c) ? a_exp : last_stored;
            exp_v = {e_ready, e_busy, (c == 1), (in_win && dv), e_store, e_store, exp_stray, e_addr};
            n_cmp++;
            if (observed() !== exp_v) begin
                n_err++;
                $display("FAIL tile len=%0d c=%0d got=%b exp=%b", len, c, observed(), exp_v);
            end
            if (store_output === 1'b1) begin
                got_a = (exp_q.size() > 0) ? exp_q.pop_front() : ~op_buffer_address;
                n_cmp++;
                if (op_buffer_address !== got_a) begin
                    n_err++;
                    $display("FAIL store_addr got=%0d exp=%0d", op_buffer_address, got_a);
                end
            end
            if (!in_win && dv) exp_stray = 1'b1;
            if (store_c >= 0 && c == store_c + 1) begin
                fin = 1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL tile_timeout len=%0d got=running exp=finished", len);
        end
        last_stored = a_exp;
        exp_ptr     = exp_ptr + 1'b1;
        step();
    endtask

    task automatic test_reset_mid_tile();
        logic [VW-1:0] exp_v;
        for (int c = 0; c < 10; c++) begin
            cmd_if.cmd_valid = (c == 0);
            cmd_if.cmd_len   = CNT_W'(8);
            cmd_if.cmd_addr  = ADDR_W'(3);
            data_valid       = (c >= 2 && c <= 5);
            rst              = (c >= 6 && c <= 8);
            #1;
            if (c >= 6) begin
                n_cmp++;
                if ({acc_reset, store_output, done} !== 3'b000) begin
                    n_err++;
                    $display("FAIL mid_reset_pulse c=%0d got=%b exp=000", c, {acc_reset, store_output, done});
                end
            end
            if (c == 9) begin
                exp_v = {1'b1, 6'b0, {ADDR_W{1'b0}}};
                n_cmp++;
                if (observed() !== exp_v) begin
                    n_err++;
                    $display("FAIL mid_reset_idle got=%b exp=%b", observed(), exp_v);
                end
            end
            step();
        end
        model_reset();
    endtask

    task automatic test_basic();
        run_tile(4, ADDR_W'(5), 100, 0);
    endtask

    task automatic test_gaps();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_tile(3, ADDR_W'(7), -1, 0);
    endtask

    task automatic test_zero_len();
        run_tile(0, ADDR_W'(9), 100, 0);
    endtask

    // cmd_valid held high across both commands; the second waits for the first STORE.
    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a1, a2, e_addr, got_a;
        logic [VW-1:0]     exp_v;
        bit                dv, e_ready, e_store;
`ifdef ACC_SEQ_ADDR_AUTOINC_EN
        a1 = exp_ptr; a2 = exp_ptr + 1'b1;
`else
        a1 = ADDR_W'(1); a2 = ADDR_W'(2);
`endif
        exp_q.push_back(a1);
        exp_q.push_back(a2);
        for (int c = 0; c < 15; c++) begin
            dv = (c == 2 || c == 3 || c == 9 || c == 10);
            cmd_if.cmd_valid = (c <= 7);
            cmd_if.cmd_len   = CNT_W'(2);
            cmd_if.cmd_addr  = (c <= 6) ? ADDR_W'(1) : ADDR_W'(2);
            data_valid       = dv;
            #1;
            e_ready = (c == 0 || c == 7 || c == 14);
            e_store = (c == 6 || c == 13);
            e_addr  = (c < 6) ? last_stored : (c < 13) ? a1 : a2;
            exp_v = {e_ready, !e_ready, (c == 1 || c == 8), dv, e_store, e_store, exp_stray, e_addr};
            n_cmp++;
            if (observed() !== exp_v) begin
                n_err++;
                $display("FAIL b2b c=%0d got=%b exp=%b", c, observed(), exp_v);
            end
            if (store_output === 1'b1) begin
                got_a = (exp_q.size() > 0) ? exp_q.pop_front() : ~op_buffer_address;
                n_cmp++;
                if (op_buffer_address !== got_a) begin
                    n_err++;
                    $display("FAIL b2b_store_addr got=%0d exp=%0d", op_buffer_address, got_a);
                end
            end
            step();
        end
        last_stored = a2;
        exp_ptr     = exp_ptr + 2'd2;
    endtask

    task automatic test_stray();
        cmd_if.cmd_valid = 1'b0;
        data_valid = 1'b1;
        #1;
        n_cmp++;
        if (stray_beat !== exp_stray) begin
            n_err++;
            $display("FAIL stray_before got=%b exp=%b", stray_beat, exp_stray);
        end
        exp_stray = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (stray_beat !== 1'b1) begin
                n_err++;
                $display("FAIL stray_sticky got=%b exp=1", stray_beat);
            end
            step();
        end
        run_tile(5, ADDR_W'($urandom_range(0, 15)), 60, 1);
    endtask

    task automatic test_random_tiles(input int n);
        for (int i = 0; i < n; i++)
            run_tile($urandom_range(0, 12), ADDR_W'($urandom_range(0, 15)), $urandom_range(30, 100), 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_tile();
        test_basic();
        test_gaps();
        test_zero_len();
        test_back_to_back();
        test_stray();
        test_reset();
        test_random_tiles(17);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
